// File: rtl/apb_pkg.sv
// Shared APB definitions: bus-phase encoding and default bus widths.
package apb_pkg;

    // Bus phase as seen by a requester or completer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_DATA_WIDTH = 8;
    localparam int APB_ADDR_WIDTH = 7;

endpackage

// File: rtl/apb_mem_array.sv
// Word storage for the APB completer: synchronous write, registered read,
// asynchronous clear of every word and of the read register.
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DW    = APB_DATA_WIDTH,
    parameter int AW    = APB_ADDR_WIDTH - 1,
    parameter int DEPTH = 48
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rzero_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic          wr_ok, rd_ok;

    assign wr_ok   = {1'b0, waddr_i} < DEPTH_C;
    assign rd_ok   = {1'b0, raddr_i} < DEPTH_C;
    assign rdata_o = rdata_q;

    // Storage and read register; rzero_i forces the read value to zero (address error).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i && wr_ok) mem_q[waddr_i] <= wdata_i;
            if (re_i) rdata_q <= (rzero_i || !rd_ok) ? '0 : mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// Memory-backed APB completer with programmable wait states, address-error
// response and a sticky protocol-violation flag.
//
// The state register only ever holds IDLE or ACCESS. SETUP is the cycle in
// which the bus shows PSEL=1/PENABLE=0 while we are IDLE; it is decoded
// combinationally so the transfer registers and (for zero wait states) the
// registered PREADY/PRDATA are loaded at the edge closing the setup phase,
// putting PREADY high in the first access cycle.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DEPTH       = 48,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  prot_err
);

    localparam int           LAW     = ADDR_WIDTH - 1;
    localparam logic [LAW:0] DEPTH_C = DEPTH[LAW:0];
    localparam logic [3:0]   WS_C    = 4'(WAIT_STATES);

    apb_state_e     state_q, state_d, phase;
    logic           write_q, write_d;
    logic [LAW-1:0] addr_q, addr_d;
    logic           aerr_q, aerr_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           pready_q, pready_d;
    logic           pslverr_q, pslverr_d;
    logic           prot_err_q, prot_err_d;

    logic [LAW-1:0] local_addr;
    logic           local_aerr;
    logic           mem_we, mem_re, mem_rzero;
    logic [LAW-1:0] mem_raddr;
    logic           unused_sel_bit;

    // The top address bit is the requester's select bit and carries no meaning here.
    assign unused_sel_bit = PADDR[ADDR_WIDTH-1];
    assign local_addr     = PADDR[LAW-1:0];
    assign local_aerr     = {1'b0, local_addr} >= DEPTH_C;

    // Decode the current bus phase, recognising SETUP directly from the bus.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && PSEL && !PENABLE) phase = SETUP;
    end

    // Next-state, transfer registers, response and storage control.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        aerr_d     = aerr_q;
        wait_cnt_d = wait_cnt_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prot_err_d = prot_err_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_rzero  = aerr_q;
        mem_raddr  = addr_q;
        case (phase)
            IDLE: begin
                // Access phase with no preceding setup: flag it, give no response.
                if (PSEL && PENABLE) prot_err_d = 1'b1;
            end
            SETUP: begin
                write_d    = PWRITE;
                addr_d     = local_addr;
                aerr_d     = local_aerr;
                wait_cnt_d = WS_C;
                state_d    = ACCESS;
                if (WAIT_STATES == 0) begin
                    pready_d  = 1'b1;
                    pslverr_d = local_aerr;
                    mem_re    = !PWRITE || local_aerr;
                    mem_raddr = local_addr;
                    mem_rzero = local_aerr;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Requester abandoned the transfer: nothing is written.
                    state_d    = IDLE;
                    pready_d   = 1'b0;
                    pslverr_d  = 1'b0;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = aerr_q;
                        mem_re    = !write_q || aerr_q;
                    end
                end else if (pready_q && PENABLE) begin
                    // Completion edge: write data is taken from the bus now.
                    mem_we    = write_q && !aerr_q;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            aerr_q     <= 1'b0;
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            aerr_q     <= aerr_d;
            wait_cnt_q <= wait_cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prot_err_q <= prot_err_d;
        end
    end

    apb_mem_array #(
        .DW    (DATA_WIDTH),
        .AW    (LAW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_ni  (PRESET),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (PWDATA),
        .re_i    (mem_re),
        .rzero_i (mem_rzero),
        .raddr_i (mem_raddr),
        .rdata_o (PRDATA)
    );

    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign prot_err = prot_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one zero-wait instance and one
// three-wait-state instance, each driven by its own bus.
module tb_apb_slave_mem;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [6:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];
    logic       perr    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(48), .WAIT_STATES(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .prot_err(perr[0])
    );

    apb_slave_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(48), .WAIT_STATES(3)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .prot_err(perr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer starting just after a rising edge; returns just after the
    // completion edge with the bus idle, so a following call is back-to-back.
    task automatic xfer(input bit d, input logic wr, input logic [6:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int lat);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(negedge PCLK);
        check("setup_pready", 32'(pready[d]), 0);
        @(posedge PCLK); #1;
        penable[d] = 1'b1;
        lat = 1;
        @(negedge PCLK);
        while (pready[d] !== 1'b1 && lat < 20) begin
            @(posedge PCLK); #1;
            lat++;
            @(negedge PCLK);
        end
        check("pready_seen", 32'(pready[d]), 1);
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge PCLK); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         lat;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end

        // Reset values
        @(negedge PCLK);
        check("rst_pready0", 32'(pready[0]), 0);
        check("rst_prdata0", 32'(prdata[0]), 0);
        check("rst_pslverr0", 32'(pslverr[0]), 0);
        check("rst_prot0", 32'(perr[0]), 0);
        check("rst_pready3", 32'(pready[1]), 0);
        #2 PRESET = 1'b1;
        @(posedge PCLK); #1;

        // Zero wait states: write then read
        xfer(0, 1'b1, 7'h05, 8'hA5, rd, err, lat);
        check("wr05_lat", lat, 1);
        check("wr05_err", 32'(err), 0);
        xfer(0, 1'b0, 7'h05, 8'h00, rd, err, lat);
        check("rd05_lat", lat, 1);
        check("rd05_data", 32'(rd), 32'hA5);
        check("rd05_err", 32'(err), 0);
        // Select bit in PADDR[6] is ignored
        xfer(0, 1'b0, 7'h45, 8'h00, rd, err, lat);
        check("rd45_data", 32'(rd), 32'hA5);
        // Back-to-back write/read of the last legal word
        xfer(0, 1'b1, 7'd47, 8'h5A, rd, err, lat);
        check("wr47_err", 32'(err), 0);
        xfer(0, 1'b0, 7'd47, 8'h00, rd, err, lat);
        check("rd47_data", 32'(rd), 32'h5A);

        // Three wait states
        xfer(1, 1'b1, 7'h10, 8'h3C, rd, err, lat);
        check("ws3_wr_lat", lat, 4);
        xfer(1, 1'b0, 7'h10, 8'h00, rd, err, lat);
        check("ws3_rd_lat", lat, 4);
        check("ws3_rd_data", 32'(rd), 32'h3C);
        check("ws3_rd_err", 32'(err), 0);

        // Out-of-range addresses
        xfer(0, 1'b1, 7'd50, 8'h77, rd, err, lat);
        check("wr50_err", 32'(err), 1);
        check("wr50_lat", lat, 1);
        xfer(0, 1'b0, 7'd50, 8'h00, rd, err, lat);
        check("rd50_err", 32'(err), 1);
        check("rd50_data", 32'(rd), 0);
        xfer(0, 1'b0, 7'd48, 8'h00, rd, err, lat);
        check("rd48_err", 32'(err), 1);
        xfer(0, 1'b0, 7'd47, 8'h00, rd, err, lat);
        check("oor_rd47", 32'(rd), 32'h5A);
        check("oor_rd47_err", 32'(err), 0);
        xfer(0, 1'b0, 7'd5, 8'h00, rd, err, lat);
        check("oor_rd05", 32'(rd), 32'hA5);
        xfer(0, 1'b0, 7'd2, 8'h00, rd, err, lat);
        check("oor_rd02", 32'(rd), 0);
        xfer(0, 1'b0, 7'd18, 8'h00, rd, err, lat);
        check("oor_rd18", 32'(rd), 0);
        xfer(0, 1'b0, 7'd0, 8'h00, rd, err, lat);
        check("oor_rd00", 32'(rd), 0);

        // Abort: PSEL dropped in the second access cycle of a wait-state write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 7'h10; pwdata[1] = 8'h99;
        @(posedge PCLK); #1;
        penable[1] = 1'b1;
        @(negedge PCLK);
        check("abort_c1", 32'(pready[1]), 0);
        @(posedge PCLK); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("abort_nordy", 32'(pready[1]), 0);
        end
        @(posedge PCLK); #1;
        xfer(1, 1'b0, 7'h10, 8'h00, rd, err, lat);
        check("abort_keep", 32'(rd), 32'h3C);
        check("abort_rd_lat", lat, 4);

        // Protocol violation: access phase straight from IDLE
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 7'h05;
        @(negedge PCLK);
        check("prot_before", 32'(perr[0]), 0);
        @(posedge PCLK); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge PCLK);
        check("prot_set", 32'(perr[0]), 1);
        check("prot_nordy", 32'(pready[0]), 0);
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 7'h05, 8'h00, rd, err, lat);
        check("prot_xfer_data", 32'(rd), 32'hA5);
        check("prot_xfer_lat", lat, 1);
        check("prot_sticky", 32'(perr[0]), 1);

        // Reset in the middle of an access
        xfer(0, 1'b1, 7'h20, 8'h11, rd, err, lat);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 7'h20;
        @(posedge PCLK); #1;
        penable[0] = 1'b1;
        @(negedge PCLK);
        check("prerst_pready", 32'(pready[0]), 1);
        check("prerst_prdata", 32'(prdata[0]), 32'h11);
        #2 PRESET = 1'b0;
        #1;
        check("arst_pready", 32'(pready[0]), 0);
        check("arst_prdata", 32'(prdata[0]), 0);
        check("arst_pslverr", 32'(pslverr[0]), 0);
        check("arst_prot", 32'(perr[0]), 0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        #1 PRESET = 1'b1;
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 7'h20, 8'h00, rd, err, lat);
        check("postrst_rd20", 32'(rd), 0);
        xfer(0, 1'b0, 7'h05, 8'h00, rd, err, lat);
        check("postrst_rd05", 32'(rd), 0);
        xfer(1, 1'b0, 7'h10, 8'h00, rd, err, lat);
        check("postrst_rd10_ws3", 32'(rd), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

- Memory-backed APB completer: byte-wide register file with a programmable wait-state count and error signalling.
- Sits directly downstream of the APB requester. One instance per select line, PSELECT1 or PSELECT2.
- Consumes PSEL, PENABLE, PWRITE, PADDR and PWDATA; returns PRDATA, PREADY and PSLVERR.

## Interface
Parameters:
- DATA_WIDTH, 8: width of PWDATA, PRDATA and each storage word.
- ADDR_WIDTH, 7: width of PADDR. Bit ADDR_WIDTH-1 is the requester's slave-select bit and is ignored here.
- DEPTH, 48: number of implemented words. Legal local addresses are 0..DEPTH-1; DEPTH ≤ 2^(ADDR_WIDTH-1).
- WAIT_STATES, 0: extra ACCESS cycles with PREADY low before completion. Range 0..15.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- PCLK, in, 1: clock, rising edge.
- PRESET, in, 1: asynchronous active-low reset.
- PSEL, in, 1: slave select.
- PENABLE, in, 1: access phase indicator.
- PWRITE, in, 1: 1 = write, 0 = read.
- PADDR, in, ADDR_WIDTH: address. The local address is PADDR[ADDR_WIDTH-2:0].
- PWDATA, in, DATA_WIDTH: write data.
- PRDATA, out, DATA_WIDTH: read data, registered.
- PREADY, out, 1: transfer complete, registered.
- PSLVERR, out, 1: transfer error, registered. Valid only while PREADY=1.
- prot_err, out, 1: sticky flag for a protocol violation. Cleared only by reset.

## Operation
States are IDLE, SETUP and ACCESS. The state encoding belongs in a shared package.
- IDLE
  - PSEL=1, PENABLE=0 → SETUP.
  - PSEL=1, PENABLE=1 (access without a setup phase) → set prot_err; stay IDLE; no response.
- SETUP (one cycle)
  - Latch PWRITE, the local address and an address-error flag (local address ≥ DEPTH) into the transfer registers.
  - Load wait_cnt ← WAIT_STATES.
  - Go to ACCESS unconditionally.
  - PREADY is driven to 1 at this edge only if WAIT_STATES=0.
- ACCESS
  - PSEL=0: abort. Go to IDLE, PREADY←0, no write, no error.
  - wait_cnt>0: decrement. PREADY←1 at the edge where wait_cnt goes 1→0.
  - PREADY=1 and PSEL=1 and PENABLE=1: the transfer completes at this edge.
    - Write, no error: mem[addr] ← PWDATA, sampled at the completing edge.
    - Read: PRDATA was loaded with mem[addr] on the same edge that set PREADY.
    - Address error: PSLVERR is 1 together with PREADY, PRDATA=0, memory unchanged.
    - After completing, PREADY←0 and PSLVERR←0.
    - Next state is SETUP if PSEL=1 and PENABLE=0 in that cycle, otherwise IDLE.
  - Any change of PADDR, PWRITE or PWDATA during ACCESS is ignored: the latched address and direction are used. The sole exception is PWDATA, which is sampled at the completion edge.
- Reset values
  - State: IDLE.
  - Outputs: PRDATA=0, PREADY=0, PSLVERR=0, prot_err=0.
  - wait_cnt=0; all memory words = 0.
- Reset mid-transfer: asynchronous return to IDLE. Any in-flight write is lost.

## Timing
- Zero-wait transfer: two cycles (SETUP, ACCESS). PREADY is high in the first ACCESS cycle.
- N wait states: N+2 cycles. PREADY is high only in the final ACCESS cycle.
- Back-to-back transfers need no IDLE cycle between them.
- PREADY is asserted for exactly one cycle per completed transfer.
- A read of a word written by the immediately preceding transfer returns the new value.

## Structure
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS), shared with the requester;
  - DATA_WIDTH and ADDR_WIDTH defaults.
- One natural sub-module, apb_mem_array: synchronous-write, registered-read storage with an async-clear port. The FSM, wait counter and error logic stay in apb_slave_mem.

## Test plan
- Write, WAIT_STATES=0: write 0xA5 to addr 0x05, then read 0x05 → PREADY high in the 2nd cycle of each transfer, PRDATA=0xA5, PSLVERR=0.
- WAIT_STATES=3: read addr 0x10 after writing 0x3C → PREADY low for 3 ACCESS cycles, high in the 4th, PRDATA=0x3C.
- Out-of-range address: write 0x77 to local addr 50 (DEPTH=48) → PSLVERR=1 with PREADY. A following read of addr 50 gives PSLVERR=1, PRDATA=0; addrs 0..47 are unchanged.
- Abort: drop PSEL in the 2nd ACCESS cycle of a write with WAIT_STATES=3 → no PREADY, word keeps its old value, FSM returns to IDLE.
- Protocol violation: PSEL=1, PENABLE=1 from IDLE → prot_err=1 and stays 1; a subsequent legal transfer still completes normally.
- Reset: assert PRESET low mid-ACCESS → outputs go to 0 immediately (no clock edge). A read of any previously written word after reset returns 0.
